// File: rtl/tx_arb_pkg.sv
// Shared types and constants for the TX FIFO write-side arbiter.
//   arb_state_e : write-port FSM states (idle, single reg byte, ALU low byte, ALU high byte)
//   requester_e : identity of a requester, used for the round-robin flag
//   BYTE_W      : width of one FIFO entry
package tx_arb_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REG_B  = 2'd1,
    ALU_LO = 2'd2,
    ALU_HI = 2'd3
  } arb_state_e;

  typedef enum logic {
    REQ_ALU = 1'b0,
    REQ_REG = 1'b1
  } requester_e;

endpackage

// File: rtl/req_hold_slot.sv
// One-deep holding register for a single requester, with overflow detection.
//   clk, rst     : clock and synchronous active-high reset
//   valid, data  : 1-cycle request strobe and its payload
//   slot_release : the arbiter takes the held request at this edge
//   pend         : a request is held (registered)
//   hold         : the held payload (registered)
//   ovf          : sticky, a strobe arrived while the slot was full and not being released
module req_hold_slot #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         valid,
  input  logic [W-1:0] data,
  input  logic         slot_release,
  output logic         pend,
  output logic [W-1:0] hold,
  output logic         ovf
);

  logic         pend_r;
  logic [W-1:0] hold_r;
  logic         ovf_r;

  // Capture, release and overflow tracking for the single slot entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_r <= 1'b0;
      hold_r <= '0;
      ovf_r  <= 1'b0;
    end else begin
      // A slot being released at this edge counts as free, so a new strobe
      // landing on the grant edge is kept rather than dropped.
      if (valid && (!pend_r || slot_release)) begin
        pend_r <= 1'b1;
        hold_r <= data;
      end else if (valid) begin
        ovf_r  <= 1'b1;
      end else if (slot_release) begin
        pend_r <= 1'b0;
      end
    end
  end

  assign pend = pend_r;
  assign hold = hold_r;
  assign ovf  = ovf_r;

endmodule

// File: rtl/tx_fifo_wr_arbiter.sv
// Write-side scheduler for the TX async FIFO, in the FIFO write-clock domain.
// Shares the single FIFO write port between a 16-bit ALU result (sent low byte
// first) and 8-bit register-file read data, round-robin, throttled by full.
//   clk, rst             : write clock, synchronous active-high reset
//   alu_valid, alu_data  : ALU result strobe and data
//   reg_valid, reg_data  : register-file read strobe and data
//   full                 : FIFO full flag
//   w_inc, wdata         : FIFO write enable and write data
//   alu_busy, reg_busy   : requester slot occupied
//   ovf_err              : sticky, a strobe was dropped because its slot was occupied
module tx_fifo_wr_arbiter
  import tx_arb_pkg::*;
#(
  parameter int DATA_WIDTH = BYTE_W,
  parameter int ALU_WIDTH  = 2 * DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alu_valid,
  input  logic [ALU_WIDTH-1:0]  alu_data,
  input  logic                  reg_valid,
  input  logic [DATA_WIDTH-1:0] reg_data,
  input  logic                  full,
  output logic                  w_inc,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic                  alu_busy,
  output logic                  reg_busy,
  output logic                  ovf_err
);

  arb_state_e            state_r;
  arb_state_e            next_state_s;
  arb_state_e            grant_state_s;
  requester_e            last_grant_r;
  requester_e            win_s;
  logic [ALU_WIDTH-1:0]  tx_buf_r;
  logic                  grant_s;
  logic                  any_pend_s;
  logic                  w_inc_s;
  logic                  alu_pend_s;
  logic                  reg_pend_s;
  logic                  alu_ovf_s;
  logic                  reg_ovf_s;
  logic                  alu_rel_s;
  logic                  reg_rel_s;
  logic [ALU_WIDTH-1:0]  alu_hold_s;
  logic [DATA_WIDTH-1:0] reg_hold_s;

  req_hold_slot #(.W(ALU_WIDTH)) u_alu_slot (
    .clk          (clk),
    .rst          (rst),
    .valid        (alu_valid),
    .data         (alu_data),
    .slot_release (alu_rel_s),
    .pend         (alu_pend_s),
    .hold         (alu_hold_s),
    .ovf          (alu_ovf_s)
  );

  req_hold_slot #(.W(DATA_WIDTH)) u_reg_slot (
    .clk          (clk),
    .rst          (rst),
    .valid        (reg_valid),
    .data         (reg_data),
    .slot_release (reg_rel_s),
    .pend         (reg_pend_s),
    .hold         (reg_hold_s),
    .ovf          (reg_ovf_s)
  );

  // Arbitration, write enable and next-state decode.
  always_comb begin
    next_state_s  = state_r;
    grant_s       = 1'b0;
    win_s         = REQ_ALU;
    grant_state_s = ALU_LO;
    any_pend_s    = alu_pend_s | reg_pend_s;
    w_inc_s       = (state_r != IDLE) && !full && !rst;

    // With both pending, the requester that did not win last time goes first.
    if (alu_pend_s && reg_pend_s) begin
      win_s = (last_grant_r == REQ_ALU) ? REQ_REG : REQ_ALU;
    end else if (reg_pend_s) begin
      win_s = REQ_REG;
    end else begin
      win_s = REQ_ALU;
    end

    if (win_s == REQ_REG) begin
      grant_state_s = REG_B;
    end else begin
      grant_state_s = ALU_LO;
    end

    case (state_r)
      IDLE: begin
        if (any_pend_s) begin
          grant_s      = 1'b1;
          next_state_s = grant_state_s;
        end else begin
          next_state_s = IDLE;
        end
      end
      ALU_LO: begin
        if (w_inc_s) begin
          next_state_s = ALU_HI;
        end else begin
          next_state_s = ALU_LO;
        end
      end
      REG_B, ALU_HI: begin
        // Re-grant on the edge that writes the last byte so transfers run back to back.
        if (w_inc_s && any_pend_s) begin
          grant_s      = 1'b1;
          next_state_s = grant_state_s;
        end else if (w_inc_s) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = state_r;
        end
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  assign alu_rel_s = grant_s && (win_s == REQ_ALU);
  assign reg_rel_s = grant_s && (win_s == REQ_REG);

  // State register, round-robin flag and transmit buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      last_grant_r <= REQ_REG;
      tx_buf_r     <= '0;
    end else begin
      state_r <= next_state_s;
      if (grant_s) begin
        last_grant_r <= win_s;
        if (win_s == REQ_ALU) begin
          tx_buf_r <= alu_hold_s;
        end else begin
          tx_buf_r <= {{(ALU_WIDTH-DATA_WIDTH){1'b0}}, reg_hold_s};
        end
      end
    end
  end

  assign w_inc    = w_inc_s;
  assign wdata    = (state_r == ALU_HI) ? tx_buf_r[ALU_WIDTH-1:DATA_WIDTH]
                                        : tx_buf_r[DATA_WIDTH-1:0];
  assign alu_busy = alu_pend_s;
  assign reg_busy = reg_pend_s;
  assign ovf_err  = alu_ovf_s | reg_ovf_s;

endmodule
